// File: rtl/sha256x_wrapper.sv
// sha256x_wrapper: multi-block SHA-256 / SHA-256d sequencer around a word-streaming SHA-256 core.
// Optional feature macro: SHA256X_MIDSTATE_EN (start a job from a precomputed midstate at block 1).

// One 512-bit compression: pulls words 0..15 by request/ready, then expands the schedule internally.
module sha256_stream (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [255:0] state_i,
  input  logic         rdy_i,
  input  logic [31:0]  word_i,
  output logic         req_c,
  output logic [3:0]   k_o,
  output logic         done_o,
  output logic [255:0] state_o
);
  typedef enum logic [1:0] {C_IDLE, C_WORD, C_RUN, C_FIN} cst_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  cst_e              st_q, st_d;
  logic [5:0]        t_q, t_d;
  logic [255:0]      hin_q, hin_d, work_q, work_d, hout_q, hout_d, rnd;
  logic [15:0][31:0] w_q, w_d;
  logic              done_q, done_d;
  logic [31:0]       wt, a, b, c, d, e, f, g, h, t1, t2;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One compression round; w_q[0] is W[t-16], w_q[15] is W[t-1].
  always_comb begin
    {a, b, c, d, e, f, g, h} = work_q;
    wt = (st_q == C_WORD) ? word_i
       : (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
         + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    t1  = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t_q] + wt;
    t2  = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    rnd = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

  // Core state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= C_IDLE; t_q <= '0; hin_q <= '0; work_q <= '0; w_q <= '0; hout_q <= '0; done_q <= 1'b0;
    end else begin
      st_q <= st_d; t_q <= t_d; hin_q <= hin_d; work_q <= work_d; w_q <= w_d; hout_q <= hout_d; done_q <= done_d;
    end
  end

  // Core sequencing: 16 fetched rounds, 48 internal rounds, final feed-forward add.
  always_comb begin
    st_d = st_q; t_d = t_q; hin_d = hin_q; work_d = work_q; w_d = w_q; hout_d = hout_q; done_d = 1'b0;
    case (st_q)
      C_IDLE: if (start_i) begin
        hin_d = state_i; work_d = state_i; t_d = '0; st_d = C_WORD;
      end
      C_WORD: if (rdy_i) begin
        work_d = rnd; w_d = {wt, w_q[15:1]}; t_d = t_q + 6'd1;
        if (t_q == 6'd15) st_d = C_RUN;
      end
      C_RUN: begin
        work_d = rnd; w_d = {wt, w_q[15:1]}; t_d = t_q + 6'd1;
        if (t_q == 6'd63) st_d = C_FIN;
      end
      C_FIN: begin
        for (int i = 0; i < 8; i++) hout_d[i*32 +: 32] = hin_q[i*32 +: 32] + work_q[i*32 +: 32];
        done_d = 1'b1; st_d = C_IDLE;
      end
      default: st_d = C_IDLE;
    endcase
  end

  assign req_c   = (st_q == C_WORD);
  assign k_o     = t_q[3:0];
  assign done_o  = done_q;
  assign state_o = hout_q;
endmodule

module sha256x_wrapper #(
  parameter int unsigned MAX_WORDS = 20,
  parameter int unsigned AW        = $clog2(MAX_WORDS),
  parameter int unsigned LW        = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode_double,
  input  logic [LW-1:0] msg_words,
  input  logic          rdy,
  input  logic [31:0]   data,
  output logic [AW-1:0] addr,
  output logic          rq,
  output logic [255:0]  hash,
  output logic          done,
  output logic          busy
`ifdef SHA256X_MIDSTATE_EN
  ,
  input  logic          use_mid,
  input  logic [255:0]  midstate
`endif
);
  localparam int unsigned NB_MAX = (MAX_WORDS + 18) / 16;
  localparam int unsigned BW     = $clog2(NB_MAX + 1);
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  typedef enum logic [1:0] {S_IDLE, S_BLOCK, S_DOUBLE, S_FINISH} st_e;

  st_e           st_q, st_d;
  logic [LW-1:0] len_q, len_d;
  logic [BW-1:0] nb_q, nb_d, b_q, b_d;
  logic          dbl_q, dbl_d, done_q, done_d, busy_q, busy_d, rq_q, rq_d;
  logic          wrdy_q, wrdy_d, cstart_q, cstart_d;
  logic [255:0]  cv_q, cv_d, hash_q, hash_d, core_out, core_in;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   word_q, word_d, g, l32, lclamp32;
  logic          core_req, core_done, last_blk;
  logic [3:0]    core_k;

  assign core_in = (st_q == S_DOUBLE) ? IV : cv_q;

  sha256_stream u_core (
    .clk(clk), .rst_n(rst_n), .start_i(cstart_q), .state_i(core_in), .rdy_i(wrdy_q), .word_i(word_q),
    .req_c(core_req), .k_o(core_k), .done_o(core_done), .state_o(core_out)
  );

  // Job, sequencing and word-delivery registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= S_IDLE; len_q <= '0; nb_q <= '0; b_q <= '0; dbl_q <= 1'b0; cv_q <= '0; hash_q <= '0;
      done_q <= 1'b0; busy_q <= 1'b0; rq_q <= 1'b0; addr_q <= '0; wrdy_q <= 1'b0; word_q <= '0; cstart_q <= 1'b0;
    end else begin
      st_q <= st_d; len_q <= len_d; nb_q <= nb_d; b_q <= b_d; dbl_q <= dbl_d; cv_q <= cv_d; hash_q <= hash_d;
      done_q <= done_d; busy_q <= busy_d; rq_q <= rq_d; addr_q <= addr_d; wrdy_q <= wrdy_d; word_q <= word_d;
      cstart_q <= cstart_d;
    end
  end

  // Block chaining FSM plus source selection for each word the core asks for.
  always_comb begin
    st_d = st_q; len_d = len_q; nb_d = nb_q; b_d = b_q; dbl_d = dbl_q; cv_d = cv_q; hash_d = hash_q;
    done_d = 1'b0; busy_d = busy_q; rq_d = rq_q; addr_d = addr_q; wrdy_d = 1'b0; word_d = word_q;
    cstart_d = 1'b0;
    lclamp32 = (32'(msg_words) > MAX_WORDS) ? MAX_WORDS : 32'(msg_words);
    g        = 32'(b_q) * 32'd16 + 32'(core_k);
    l32      = 32'(len_q);
    last_blk = (32'(b_q) + 32'd1 == 32'(nb_q));

    case (st_q)
      S_IDLE: if (start) begin
        len_d = LW'(lclamp32); dbl_d = mode_double; nb_d = BW'((lclamp32 + 32'd18) / 32'd16);
        b_d = '0; cv_d = IV; busy_d = 1'b1; cstart_d = 1'b1; st_d = S_BLOCK;
`ifdef SHA256X_MIDSTATE_EN
        if (use_mid && lclamp32 >= 32'd16) begin
          cv_d = midstate; b_d = BW'(1);
        end
`endif
      end
      S_BLOCK: if (core_done) begin
        cv_d = core_out; b_d = b_q + BW'(1);
        cstart_d = !last_blk || dbl_q;
        if (last_blk) st_d = dbl_q ? S_DOUBLE : S_FINISH;
      end
      S_DOUBLE: if (core_done) begin
        cv_d = core_out; st_d = S_FINISH;
      end
      S_FINISH: begin
        hash_d = cv_q; done_d = 1'b1; busy_d = 1'b0; st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase

    // A new word is sourced only when no fetch or delivery is already in flight.
    if (rq_q) begin
      if (rdy) begin
        rq_d = 1'b0; wrdy_d = 1'b1; word_d = data;
      end
    end else if (core_req && !wrdy_q && (st_q == S_BLOCK || st_q == S_DOUBLE)) begin
      if (st_q == S_DOUBLE) begin
        wrdy_d = 1'b1;
        word_d = '0;
        for (int i = 0; i < 8; i++) if (core_k == 4'(i)) word_d = cv_q[(7-i)*32 +: 32];
        if (core_k == 4'd8)  word_d = 32'h8000_0000;
        if (core_k == 4'd15) word_d = 32'h0000_0100;
      end else if (g < l32) begin
        rq_d = 1'b1; addr_d = AW'(g);
      end else begin
        wrdy_d = 1'b1;
        if (g == l32)                      word_d = 32'h8000_0000;
        else if (last_blk && core_k == 14) word_d = l32 >> 27;
        else if (last_blk && core_k == 15) word_d = l32 << 5;
        else                               word_d = '0;
      end
    end
  end

  assign addr = addr_q;
  assign rq   = rq_q;
  assign hash = hash_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_sha256x_wrapper.sv
// Self-checking bench for sha256x_wrapper: software SHA-256 model, bus responder and per-cycle monitor.
`timescale 1ns/1ps
module tb_sha256x_wrapper;
  localparam int MW = 20;
  localparam int AW = 5;
  localparam int LW = 5;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] H_EMPTY   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] H_ABCD    = 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;
  localparam logic [255:0] H_GENESIS = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [31:0] GENESIS [20] = '{
    32'h01000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
    32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode_double = 1'b0, rdy = 1'b0;
  logic [LW-1:0] msg_words = '0;
  logic [31:0]   data = '0;
  logic [AW-1:0] addr;
  logic          rq, done, busy;
  logic [255:0]  hash;
`ifdef SHA256X_MIDSTATE_EN
  logic          use_mid = 1'b0;
  logic [255:0]  midstate = '0;
`endif

  sha256x_wrapper #(.MAX_WORDS(MW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_double(mode_double), .msg_words(msg_words),
    .rdy(rdy), .data(data), .addr(addr), .rq(rq), .hash(hash), .done(done), .busy(busy)
`ifdef SHA256X_MIDSTATE_EN
    , .use_mid(use_mid), .midstate(midstate)
`endif
  );

  always #5 clk = ~clk;

  int           checks = 0, errors = 0;
  logic [31:0]  mem [MW];
  int           exp_addr [$];
  logic [255:0] exp_hash = '0;
  bit           mon_en = 1'b0, stall_en = 1'b0;
  int           nreq = 0;
  logic         rq_p = 1'b0, rdy_p = 1'b0, done_p = 1'b0;
  logic [AW-1:0] addr_p = '0;

  task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of one 16-word block.
  function automatic logic [255:0] compress(input logic [255:0] cv, input logic [31:0] blk [16]);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = cv[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = cv[255-32*i -: 32] + v[i];
    return r;
  endfunction

  // Full message hash of mem[0..l-1], with standard bit-level padding, optionally hashed twice.
  function automatic logic [255:0] sha_model(input int l, input bit dbl);
    logic [31:0] p [32];
    logic [31:0] blk [16];
    logic [255:0] cv;
    int nb;
    nb = (l * 32 + 1 + 64 + 511) / 512;
    for (int i = 0; i < 32; i++) p[i] = 32'h0;
    for (int i = 0; i < l; i++) p[i] = mem[i];
    p[l] = 32'h8000_0000;
    p[nb*16-1] = 32'(l * 32);
    cv = IV;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 16; k++) blk[k] = p[b*16+k];
      cv = compress(cv, blk);
    end
    if (dbl) begin
      for (int k = 0; k < 16; k++) blk[k] = (k < 8) ? cv[255-32*k -: 32] : 32'h0;
      blk[8] = 32'h8000_0000;
      blk[15] = 32'h0000_0100;
      cv = compress(IV, blk);
    end
    return cv;
  endfunction

  // Per-cycle monitor and bus responder; rdy/data are re-driven after the checks.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rq && !rq_p) begin
        nreq++;
        if (exp_addr.size() == 0) chk(1'b0, "unexpected_rq", 256'(addr), 256'(0));
        else begin
          chk(addr == AW'(exp_addr[0]), "rq_addr", 256'(addr), 256'(exp_addr[0]));
          void'(exp_addr.pop_front());
        end
      end
      if (rq && rq_p && !rdy_p) chk(addr == addr_p, "addr_hold", 256'(addr), 256'(addr_p));
      if (rq_p && rdy_p) chk(!rq, "rq_drop", 256'(rq), 256'(0));
      if (done) begin
        chk(hash == exp_hash, "model_hash", hash, exp_hash);
        chk(!done_p, "done_pulse", 256'(done_p), 256'(0));
      end
    end
    rq_p = rq; rdy_p = rdy; addr_p = addr; done_p = done;
    rdy  = rq && (!stall_en || ($urandom_range(0, 2) == 0));
    data = (rq && int'(addr) < MW) ? mem[addr] : 32'hdead_beef;
  end

  task automatic run_job(input int mw, input bit dbl, input bit stl, input int first, input bit poke,
                         output int lat);
    int l;
    l = (mw > MW) ? MW : mw;
    exp_addr.delete();
    for (int i = first; i < l; i++) exp_addr.push_back(i);
    exp_hash = sha_model(l, dbl);
    stall_en = stl; nreq = 0;
    @(negedge clk);
    msg_words = LW'(mw); mode_double = dbl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(busy == 1'b1, "busy_after_start", 256'(busy), 256'(1));
    lat = 1;
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 20) begin start = 1'b1; msg_words = LW'(0); mode_double = ~dbl; end
      if (poke && lat == 21) start = 1'b0;
    end
    chk(done == 1'b1, "done_timeout", 256'(done), 256'(1));
    chk(busy == 1'b0, "busy_at_done", 256'(busy), 256'(0));
    @(negedge clk);
    chk(done == 1'b0, "done_one_cycle", 256'(done), 256'(1'b0));
    chk(nreq == l - first, "req_count", 256'(nreq), 256'(l - first));
    chk(exp_addr.size() == 0, "all_fetched", 256'(exp_addr.size()), 256'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat13, lat14, lat;
    for (int i = 0; i < MW; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk(rq == 0 && addr == 0 && done == 0 && busy == 0, "reset_ctrl", 256'({rq, addr, done, busy}), 256'(0));
    chk(hash == 256'h0, "reset_hash", hash, 256'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Empty message: padding-only block, no bus traffic.
    chk(sha_model(0, 1'b0) == H_EMPTY, "model_pin_empty", sha_model(0, 1'b0), H_EMPTY);
    run_job(0, 1'b0, 1'b0, 0, 1'b0, lat);
    chk(hash == H_EMPTY, "hash_empty", hash, H_EMPTY);

    // "abcd": a single fetched word.
    mem[0] = 32'h61626364;
    chk(sha_model(1, 1'b0) == H_ABCD, "model_pin_abcd", sha_model(1, 1'b0), H_ABCD);
    run_job(1, 1'b0, 1'b0, 0, 1'b0, lat);
    chk(hash == H_ABCD, "hash_abcd", hash, H_ABCD);

    // Genesis header, double hash, random bus stalls.
    for (int i = 0; i < MW; i++) mem[i] = GENESIS[i];
    chk(sha_model(20, 1'b1) == H_GENESIS, "model_pin_genesis", sha_model(20, 1'b1), H_GENESIS);
    run_job(20, 1'b1, 1'b1, 0, 1'b0, lat);
    chk(hash == H_GENESIS, "hash_genesis", hash, H_GENESIS);

    // Oversized length clamps to the full header (single hash).
    run_job(25, 1'b0, 1'b0, 0, 1'b0, lat);

    // 13 words fit one block with the length; 14 words spill the length into a second block.
    for (int i = 0; i < MW; i++) mem[i] = 32'h1111_1111 * 32'(i + 1) ^ 32'h0f0f_0f0f;
    run_job(13, 1'b0, 1'b0, 0, 1'b0, lat13);
    run_job(14, 1'b0, 1'b0, 0, 1'b0, lat14);
    chk(lat13 < 140, "one_block_latency", 256'(lat13), 256'(140));
    chk(lat14 > lat13 + 70, "two_block_latency", 256'(lat14), 256'(lat13 + 70));

    // start pulsed while busy with different parameters must not disturb the job.
    mem[0] = 32'h61626364;
    run_job(1, 1'b0, 1'b0, 0, 1'b1, lat);
    chk(hash == H_ABCD, "hash_after_busy_start", hash, H_ABCD);

    // Abort a double job mid-block with a one-cycle reset.
    for (int i = 0; i < MW; i++) mem[i] = GENESIS[i];
    mon_en = 1'b0;
    @(negedge clk);
    msg_words = LW'(20); mode_double = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk(rq == 0 && addr == 0 && done == 0 && busy == 0, "abort_ctrl", 256'({rq, addr, done, busy}), 256'(0));
    chk(hash == 256'h0, "abort_hash", hash, 256'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    mem[0] = 32'h61626364;
    run_job(1, 1'b0, 1'b0, 0, 1'b0, lat);
    chk(hash == H_ABCD, "hash_after_abort", hash, H_ABCD);

`ifdef SHA256X_MIDSTATE_EN
    // Resume from the genesis first-block midstate; only words 16..19 come from the bus.
    begin
      logic [31:0] blk [16];
      for (int i = 0; i < MW; i++) mem[i] = GENESIS[i];
      for (int k = 0; k < 16; k++) blk[k] = GENESIS[k];
      midstate = compress(IV, blk);
      use_mid = 1'b1;
      run_job(20, 1'b1, 1'b1, 16, 1'b0, lat);
      chk(hash == H_GENESIS, "hash_midstate", hash, H_GENESIS);
      use_mid = 1'b0;
    end
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
